vga_text_timing_ctrl: RTL and testbench
=======================================

Name: vga_text_timing_ctrl

Overview:
- Generates 800x600@60 VGA timing for the text display: horizontal and vertical porch/sync sequencing, `active` (display enable), `hsync` and `vsync`.
- `active` drives the `active` input of `text_counters`. This replaces free-running enables, so dot and scanline counters advance only inside the visible window.
- Also schedules CPU access to text VRAM. A req/gnt handshake grants the CPU only during vertical blanking, so display fetches never collide with writes.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch (clocks)
- H_SYNC, 128, hsync pulse width (clocks)
- H_BACK, 88, horizontal back porch (clocks)
- V_ACTIVE, 600, visible lines
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BACK, 23, vertical back porch (lines)
- SYNC_POL, 1, asserted level of hsync/vsync

Ports:
- clk  in  1  pixel clock (40 MHz)
- rst  in  1  synchronous reset, active-high
- en  in  1  timing enable; low freezes position
- active  out  1  visible pixel this cycle
- hsync  out  1  horizontal sync, level SYNC_POL when asserted
- vsync  out  1  vertical sync, level SYNC_POL when asserted
- line_end  out  1  one-cycle pulse on the last clock of each line
- frame_end  out  1  one-cycle pulse on the last clock of each frame
- vblank  out  1  high while the vertical state is not V_ACT
- cpu_req  in  1  CPU requests VRAM
- cpu_gnt  out  1  CPU owns VRAM

Behaviour:
- One clock domain. Reset is synchronous, active-high, named `rst`.

Horizontal FSM:
- States H_ACT, H_FP, H_SYNC, H_BP, each with a phase counter (11 bits).
- On each enabled clock, leave a state when its counter equals its length minus 1, then clear the counter.
- Order is H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT.
- Line length is 1056 clocks.

Vertical FSM:
- States V_ACT, V_FP, V_SYNC, V_BP, with a line counter (10 bits).
- Advances only on the last clock of H_BP, using the same order and rules as the horizontal FSM.
- Frame length is 628 lines.

Reset:
- Both FSMs go to the ACT state with counters at 0.
- All outputs are registered. Reset values: active=0, hsync=~SYNC_POL, vsync=~SYNC_POL, line_end=0, frame_end=0, vblank=0, cpu_gnt=0.

Output timing:
- Outputs reflect the internal position with exactly 1 clock of latency.
- active = (H_ACT && V_ACT). It is high for exactly 800 consecutive cycles per visible line and 600 lines per frame.
- hsync is asserted in H_SYNC on every line, including blank lines.
- vsync is asserted for all clocks of V_SYNC lines.

Enable:
- en low holds both FSMs and counters, forces active=0 and line_end/frame_end=0, and holds sync levels.
- en high resumes from the held position.

CPU grant (states IDLE, GRANT):
- IDLE -> GRANT when cpu_req && vblank-region position && not the final V_BP line. cpu_gnt=1 on the next clock.
- GRANT -> IDLE when cpu_req falls (cpu_gnt=0 on the next clock).
- GRANT -> IDLE is also forced on the first clock of the final V_BP line (line 627). This gives a 1-line guard before active video.
- A request held through active video waits and is granted one clock after the first clock of line 600 (V_FP).
- A forced drop does not re-grant until the next frame's blanking.

Other rules:
- Reset asserted mid-frame or mid-grant returns to reset values on the next edge.
- Simultaneous cpu_req rise and forced drop: forced drop wins.

Decomposition:
- Package `vga_timing_pkg` holds:
  - the `h_state_t` and `v_state_t` enums,
  - the grant state enum,
  - default 800x600 timing localparams, shared with `text_counters` and future display blocks.
- Sub-module `porch_fsm` is a generic 4-phase sequencer (ACT/FP/SYNC/BP lengths, advance input, wrap pulse output). It is instantiated twice, horizontal and vertical; the vertical instance advances on the horizontal wrap.

Test Plan:
1. Reset then 2 lines with en=1 -> active high at cycles 1..800 after release, low for 256; hsync high at line cycles 841..968; line_end pulses every 1056 cycles.
2. Run 1 full frame -> 600x800 active cycles; vsync high for exactly 4x1056 clocks, starting at line 601; frame_end pulses once per 663168 clocks.
3. cpu_req raised mid-line 100 and held -> cpu_gnt stays 0 until one clock after line 600 starts, then 1; forced to 0 at line 627 start while req is still high.
4. cpu_req pulsed for 10 cycles during line 610 -> cpu_gnt high for 10 cycles, lagging req by 1 clock, and never during active.
5. en low for 50 cycles at line 300, pixel 400 -> active=0 and position frozen; resuming gives 400 more active cycles on that line.
6. rst asserted at line 605 with cpu_gnt=1 -> next edge: all outputs at reset values; active resumes 1 clock after release.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA phase enums and default 800x600@60 timing, also used by text_counters.
package vga_timing_pkg;
    typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;
    typedef enum logic [1:0] {H_ACT, H_FP, H_SYNC, H_BP} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FP, V_SYNC, V_BP} v_state_t;
    typedef enum logic {G_IDLE, G_GRANT} gnt_state_t;
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FRONT = 40;
    localparam int DEF_H_SYNC = 128;
    localparam int DEF_H_BACK = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FRONT = 1;
    localparam int DEF_V_SYNC = 4;
    localparam int DEF_V_BACK = 23;
    localparam bit DEF_SYNC_POL = 1'b1;
endpackage

// File: rtl/vga_text_timing_ctrl_porch_fsm.sv
// porch_fsm: generic ACT/FP/SYNC/BP sequencer with per-phase counter and end-of-cycle wrap pulse.
module porch_fsm
    import vga_timing_pkg::*;
#(
    parameter int W = 11,
    parameter int L_ACT = 800,
    parameter int L_FP = 40,
    parameter int L_SYNC = 128,
    parameter int L_BP = 88
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   adv,
    output phase_t phase,
    output logic   last,
    output logic   wrap
);
    phase_t phase_q, phase_d;
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        last = cnt_q == (phase_q == PH_ACT ? W'(L_ACT - 1) :
                         phase_q == PH_FP ? W'(L_FP - 1) :
                         phase_q == PH_SYNC ? W'(L_SYNC - 1) : W'(L_BP - 1));
        cnt_d = adv ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        phase_d = !(adv && last) ? phase_q :
                  phase_q == PH_ACT ? PH_FP :
                  phase_q == PH_FP ? PH_SYNC :
                  phase_q == PH_SYNC ? PH_BP : PH_ACT;
        wrap = adv && last && phase_q == PH_BP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_ACT;
            cnt_q <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q <= cnt_d;
        end
    end
    assign phase = phase_q;
endmodule

// File: rtl/vga_text_timing_ctrl.sv
// vga_text_timing_ctrl: VGA porch/sync timing plus vblank-only CPU VRAM grant; all outputs registered.
module vga_text_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BACK = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BACK = DEF_V_BACK,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic active,
    output logic hsync,
    output logic vsync,
    output logic line_end,
    output logic frame_end,
    output logic vblank,
    input  logic cpu_req,
    output logic cpu_gnt
);
    phase_t h_phase, v_phase;
    logic h_last, h_wrap, v_last, v_wrap;
    h_state_t h_st;
    v_state_t v_st;
    logic final_line, blank_ok;
    gnt_state_t gnt_st_q, gnt_st_d;
    logic active_q, active_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic line_end_q, line_end_d, frame_end_q, frame_end_d;
    logic vblank_q, vblank_d, cpu_gnt_q, cpu_gnt_d;

    porch_fsm #(.W(11), .L_ACT(H_ACTIVE), .L_FP(H_FRONT), .L_SYNC(H_SYNC), .L_BP(H_BACK)) u_h (
        .clk(clk), .rst(rst), .adv(en), .phase(h_phase), .last(h_last), .wrap(h_wrap)
    );
    porch_fsm #(.W(10), .L_ACT(V_ACTIVE), .L_FP(V_FRONT), .L_SYNC(V_SYNC), .L_BP(V_BACK)) u_v (
        .clk(clk), .rst(rst), .adv(h_wrap), .phase(v_phase), .last(v_last), .wrap(v_wrap)
    );

    always_comb begin
        h_st = h_state_t'(h_phase);
        v_st = v_state_t'(v_phase);
        // the last back-porch line is a guard band: no new grants, existing grants are revoked
        final_line = v_st == V_BP && v_last;
        blank_ok = v_st != V_ACT && !final_line;
        active_d = en && h_st == H_ACT && v_st == V_ACT;
        hsync_d = en ? (h_st == vga_timing_pkg::H_SYNC ? SYNC_POL : !SYNC_POL) : hsync_q;
        vsync_d = en ? (v_st == vga_timing_pkg::V_SYNC ? SYNC_POL : !SYNC_POL) : vsync_q;
        line_end_d = en && h_last && h_st == H_BP;
        frame_end_d = v_wrap;
        vblank_d = v_st != V_ACT;
        gnt_st_d = gnt_st_q == G_IDLE ? (cpu_req && blank_ok ? G_GRANT : G_IDLE)
                                      : (cpu_req && !final_line ? G_GRANT : G_IDLE);
        cpu_gnt_d = gnt_st_d == G_GRANT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_st_q <= G_IDLE;
            active_q <= 1'b0;
            hsync_q <= !SYNC_POL;
            vsync_q <= !SYNC_POL;
            line_end_q <= 1'b0;
            frame_end_q <= 1'b0;
            vblank_q <= 1'b0;
            cpu_gnt_q <= 1'b0;
        end else begin
            gnt_st_q <= gnt_st_d;
            active_q <= active_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            line_end_q <= line_end_d;
            frame_end_q <= frame_end_d;
            vblank_q <= vblank_d;
            cpu_gnt_q <= cpu_gnt_d;
        end
    end

    assign active = active_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign line_end = line_end_q;
    assign frame_end = frame_end_q;
    assign vblank = vblank_q;
    assign cpu_gnt = cpu_gnt_q;
endmodule

// File: tb/tb_vga_text_timing_ctrl.sv
// tb_vga_text_timing_ctrl: directed checks of timing, enable freeze, reset and CPU grant on a scaled raster.
module tb_vga_text_timing_ctrl;
    localparam int HA = 16, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 10, VF = 1, VS = 4, VB = 3, VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, cpu_req = 1'b0;
    logic active, hsync, vsync, line_end, frame_end, vblank, cpu_gnt;
    int errors = 0, checks = 0, pos = 0;

    always #5 clk = ~clk;

    vga_text_timing_ctrl #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .active(active), .hsync(hsync), .vsync(vsync),
        .line_end(line_end), .frame_end(frame_end), .vblank(vblank),
        .cpu_req(cpu_req), .cpu_gnt(cpu_gnt)
    );

    // reference raster model from absolute frame position
    function automatic logic e_act(int p); return (p % HT) < HA && (p / HT) < VA; endfunction
    function automatic logic e_hs(int p); return (p % HT) >= HA + HF && (p % HT) < HA + HF + HS; endfunction
    function automatic logic e_vs(int p); return (p / HT) >= VA + VF && (p / HT) < VA + VF + VS; endfunction
    function automatic logic e_le(int p); return (p % HT) == HT - 1; endfunction
    function automatic logic e_fe(int p); return p == FT - 1; endfunction
    function automatic logic e_vb(int p); return (p / HT) >= VA; endfunction
    function automatic logic e_gnt(int p, logic req); return req && (p / HT) >= VA && (p / HT) != VT - 1; endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) pos = 0;
        else if (en) pos = (pos + 1) % FT;
    endtask

    task automatic goto_pos(int target);
        for (int i = 0; i < FT && pos != target; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; cpu_req = 1'b0;
        repeat (3) step();
        checks += 7;
        if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
        if (hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync got=%b exp=0", hsync); end
        if (vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync got=%b exp=0", vsync); end
        if (line_end !== 1'b0) begin errors++; $display("FAIL reset_line_end got=%b exp=0", line_end); end
        if (frame_end !== 1'b0) begin errors++; $display("FAIL reset_frame_end got=%b exp=0", frame_end); end
        if (vblank !== 1'b0) begin errors++; $display("FAIL reset_vblank got=%b exp=0", vblank); end
        if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt got=%b exp=0", cpu_gnt); end
    endtask

    task automatic test_line();
        int p, na, nl;
        na = 0; nl = 0;
        rst = 1'b0;
        for (int k = 1; k <= 2 * HT; k++) begin
            p = pos;
            step();
            checks += 3;
            if (active !== e_act(p)) begin errors++; $display("FAIL line_active cyc=%0d got=%b exp=%b", k, active, e_act(p)); end
            if (hsync !== e_hs(p)) begin errors++; $display("FAIL line_hsync cyc=%0d got=%b exp=%b", k, hsync, e_hs(p)); end
            if (line_end !== e_le(p)) begin errors++; $display("FAIL line_end cyc=%0d got=%b exp=%b", k, line_end, e_le(p)); end
            na += int'(active); nl += int'(line_end);
        end
        checks += 2;
        if (na !== 2 * HA) begin errors++; $display("FAIL line_active_count got=%0d exp=%0d", na, 2 * HA); end
        if (nl !== 2) begin errors++; $display("FAIL line_end_count got=%0d exp=2", nl); end
    endtask

    task automatic test_frame();
        int p, na, nv, nf, vs_first;
        na = 0; nv = 0; nf = 0; vs_first = -1;
        for (int k = 0; k < FT; k++) begin
            p = pos;
            step();
            checks += 6;
            if (active !== e_act(p)) begin errors++; $display("FAIL frame_active p=%0d got=%b exp=%b", p, active, e_act(p)); end
            if (hsync !== e_hs(p)) begin errors++; $display("FAIL frame_hsync p=%0d got=%b exp=%b", p, hsync, e_hs(p)); end
            if (vsync !== e_vs(p)) begin errors++; $display("FAIL frame_vsync p=%0d got=%b exp=%b", p, vsync, e_vs(p)); end
            if (line_end !== e_le(p)) begin errors++; $display("FAIL frame_line_end p=%0d got=%b exp=%b", p, line_end, e_le(p)); end
            if (frame_end !== e_fe(p)) begin errors++; $display("FAIL frame_end p=%0d got=%b exp=%b", p, frame_end, e_fe(p)); end
            if (vblank !== e_vb(p)) begin errors++; $display("FAIL frame_vblank p=%0d got=%b exp=%b", p, vblank, e_vb(p)); end
            na += int'(active); nv += int'(vsync); nf += int'(frame_end);
            if (vsync === 1'b1 && vs_first < 0) vs_first = p;
        end
        checks += 4;
        if (na !== VA * HA) begin errors++; $display("FAIL frame_active_count got=%0d exp=%0d", na, VA * HA); end
        if (nv !== VS * HT) begin errors++; $display("FAIL frame_vsync_count got=%0d exp=%0d", nv, VS * HT); end
        if (nf !== 1) begin errors++; $display("FAIL frame_end_count got=%0d exp=1", nf); end
        if (vs_first !== (VA + VF) * HT) begin errors++; $display("FAIL frame_vsync_start got=%0d exp=%0d", vs_first, (VA + VF) * HT); end
    endtask

    task automatic test_grant_hold();
        int p, n, ng, bad;
        ng = 0; bad = 0;
        goto_pos(5 * HT + 7);
        cpu_req = 1'b1;
        n = (FT - pos) + 2 * HT;
        for (int k = 0; k < n; k++) begin
            p = pos;
            step();
            checks++;
            if (cpu_gnt !== e_gnt(p, 1'b1)) begin errors++; $display("FAIL hold_gnt p=%0d got=%b exp=%b", p, cpu_gnt, e_gnt(p, 1'b1)); end
            ng += int'(cpu_gnt);
            bad += int'(cpu_gnt && active);
        end
        cpu_req = 1'b0;
        step();
        checks += 3;
        if (ng !== (VT - 1 - VA) * HT) begin errors++; $display("FAIL hold_gnt_count got=%0d exp=%0d", ng, (VT - 1 - VA) * HT); end
        if (bad !== 0) begin errors++; $display("FAIL hold_gnt_in_active got=%0d exp=0", bad); end
        if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL hold_gnt_release got=%b exp=0", cpu_gnt); end
    endtask

    task automatic test_grant_pulse();
        int p, ng, bad;
        logic r;
        ng = 0; bad = 0;
        goto_pos((VA + 2) * HT + 3);
        for (int k = 0; k < 16; k++) begin
            cpu_req = k < 10;
            r = cpu_req;
            p = pos;
            step();
            checks++;
            if (cpu_gnt !== e_gnt(p, r)) begin errors++; $display("FAIL pulse_gnt k=%0d got=%b exp=%b", k, cpu_gnt, e_gnt(p, r)); end
            ng += int'(cpu_gnt);
            bad += int'(cpu_gnt && active);
        end
        checks += 2;
        if (ng !== 10) begin errors++; $display("FAIL pulse_gnt_count got=%0d exp=10", ng); end
        if (bad !== 0) begin errors++; $display("FAIL pulse_gnt_in_active got=%0d exp=0", bad); end
    endtask

    task automatic test_enable();
        int p, na;
        goto_pos(5 * HT + HA / 2);
        en = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            checks += 5;
            if (active !== 1'b0) begin errors++; $display("FAIL en_active k=%0d got=%b exp=0", k, active); end
            if (line_end !== 1'b0) begin errors++; $display("FAIL en_line_end k=%0d got=%b exp=0", k, line_end); end
            if (frame_end !== 1'b0) begin errors++; $display("FAIL en_frame_end k=%0d got=%b exp=0", k, frame_end); end
            if (hsync !== e_hs(pos - 1)) begin errors++; $display("FAIL en_hsync_hold k=%0d got=%b exp=%b", k, hsync, e_hs(pos - 1)); end
            if (pos !== 5 * HT + HA / 2) begin errors++; $display("FAIL en_pos_frozen k=%0d got=%0d exp=%0d", k, pos, 5 * HT + HA / 2); end
        end
        en = 1'b1;
        na = 0;
        for (int k = 0; k < HT - HA / 2; k++) begin
            p = pos;
            step();
            checks++;
            if (active !== e_act(p)) begin errors++; $display("FAIL en_resume_active p=%0d got=%b exp=%b", p, active, e_act(p)); end
            na += int'(active);
        end
        checks++;
        if (na !== HA - HA / 2) begin errors++; $display("FAIL en_resume_count got=%0d exp=%0d", na, HA - HA / 2); end
        goto_pos(6 * HT + HA + HF + 2);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (hsync !== 1'b1) begin errors++; $display("FAIL en_hsync_held_high k=%0d got=%b exp=1", k, hsync); end
        end
        en = 1'b1;
        p = pos;
        step();
        checks++;
        if (hsync !== e_hs(p)) begin errors++; $display("FAIL en_hsync_resume got=%b exp=%b", hsync, e_hs(p)); end
    endtask

    task automatic test_reset_mid();
        int p;
        goto_pos((VA + 5) * HT + 3);
        cpu_req = 1'b1;
        repeat (3) step();
        checks++;
        if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_pre_gnt got=%b exp=1", cpu_gnt); end
        rst = 1'b1;
        step();
        checks += 7;
        if (active !== 1'b0) begin errors++; $display("FAIL rstmid_active got=%b exp=0", active); end
        if (hsync !== 1'b0) begin errors++; $display("FAIL rstmid_hsync got=%b exp=0", hsync); end
        if (vsync !== 1'b0) begin errors++; $display("FAIL rstmid_vsync got=%b exp=0", vsync); end
        if (line_end !== 1'b0) begin errors++; $display("FAIL rstmid_line_end got=%b exp=0", line_end); end
        if (frame_end !== 1'b0) begin errors++; $display("FAIL rstmid_frame_end got=%b exp=0", frame_end); end
        if (vblank !== 1'b0) begin errors++; $display("FAIL rstmid_vblank got=%b exp=0", vblank); end
        if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rstmid_cpu_gnt got=%b exp=0", cpu_gnt); end
        rst = 1'b0;
        cpu_req = 1'b0;
        for (int k = 0; k < HT; k++) begin
            p = pos;
            step();
            checks += 2;
            if (active !== e_act(p)) begin errors++; $display("FAIL rstmid_resume_active p=%0d got=%b exp=%b", p, active, e_act(p)); end
            if (hsync !== e_hs(p)) begin errors++; $display("FAIL rstmid_resume_hsync p=%0d got=%b exp=%b", p, hsync, e_hs(p)); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_grant_hold();
        test_grant_pulse();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
